// File: rtl/event_led_stretcher.sv
// event_led_stretcher: N-channel event-to-LED pulse stretcher.
// Each channel synchronises a raw event into clk125MHz, triggers on level or
// rising edge, and holds its LED on for HOLD_CYCLES cycles (one-shot or
// retriggerable per channel). A one-cycle 'expired' pulse marks the end of a hold.
// Optional feature macro: EVENT_COUNT_EN adds a saturating 16-bit trigger
// counter per channel (event_count output, count_clr input).
module event_led_stretcher #(
  parameter int unsigned CHANNELS    = 8,
  parameter int unsigned HOLD_CYCLES = 71072000,
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_TRIG   = 1'b0,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk125MHz,
  input  logic                    resetn,
  input  logic [CHANNELS-1:0]     event_in,
  input  logic [CHANNELS-1:0]     chan_en,
  input  logic [CHANNELS-1:0]     retrig,
  output logic [CHANNELS-1:0]     led,
  output logic [CHANNELS-1:0]     expired
`ifdef EVENT_COUNT_EN
  ,
  output logic [16*CHANNELS-1:0]  event_count,
  input  logic                    count_clr
`endif
);

  localparam int unsigned     EVT_CNT_W = 16;
  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Channel state is carried by the hold counter; this enum is its decoded view
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_LAST
  } state_e;

  logic [CHANNELS-1:0] led_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ev_d_q;
    logic                   ev_s;
    logic                   trig_c;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   led_r;
    logic                   led_d;
    logic                   exp_r;
    logic                   exp_d;
    state_e                 state_c;

    assign ev_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain plus one delay flop used for rising-edge detection
    always_ff @(posedge clk125MHz or negedge resetn) begin
      if (!resetn) begin
        sync_q <= '0;
        ev_d_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], event_in[i]};
        ev_d_q <= ev_s;
      end
    end

    // Trigger qualified by the channel enable
    assign trig_c = chan_en[i] & (EDGE_TRIG ? (ev_s & ~ev_d_q) : ev_s);

    // Decode the counter into IDLE / HOLD / LAST (LAST checked after IDLE so HOLD_CYCLES=1 skips HOLD)
    always_comb begin
      state_c = ST_HOLD;
      if (cnt_q == '0) begin
        state_c = ST_IDLE;
      end else if (cnt_q == HOLD_VAL) begin
        state_c = ST_LAST;
      end
    end

    // Next-state and output logic for one channel
    always_comb begin
      cnt_d = cnt_q;
      led_d = led_r;
      exp_d = 1'b0;
      if (!chan_en[i]) begin
        cnt_d = '0;
        led_d = 1'b0;
      end else begin
        case (state_c)
          ST_IDLE: begin
            if (trig_c) begin
              cnt_d = CNT_ONE;
              led_d = 1'b1;
            end
          end
          ST_HOLD: begin
            if (retrig[i] && trig_c) begin
              cnt_d = CNT_ONE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          ST_LAST: begin
            if (retrig[i] && trig_c) begin
              cnt_d = CNT_ONE;
            end else begin
              cnt_d = '0;
              led_d = 1'b0;
              exp_d = 1'b1;
            end
          end
          default: begin
            cnt_d = '0;
            led_d = 1'b0;
          end
        endcase
      end
    end

    // Channel state register
    always_ff @(posedge clk125MHz or negedge resetn) begin
      if (!resetn) begin
        cnt_q <= '0;
        led_r <= 1'b0;
        exp_r <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        led_r <= led_d;
        exp_r <= exp_d;
      end
    end

    assign led_q[i]   = led_r;
    assign expired[i] = exp_r;

`ifdef EVENT_COUNT_EN
    logic [EVT_CNT_W-1:0] evt_cnt_q;

    // Saturating trigger counter; clear takes priority over increment
    always_ff @(posedge clk125MHz or negedge resetn) begin
      if (!resetn) begin
        evt_cnt_q <= '0;
      end else if (count_clr) begin
        evt_cnt_q <= '0;
      end else if (trig_c && (evt_cnt_q != {EVT_CNT_W{1'b1}})) begin
        evt_cnt_q <= evt_cnt_q + EVT_CNT_W'(1);
      end
    end

    assign event_count[EVT_CNT_W*i +: EVT_CNT_W] = evt_cnt_q;
`endif
  end

  // Board polarity applied after the flop
  assign led = led_q ^ {CHANNELS{ACTIVE_LOW}};

endmodule
